if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
//  Owns the PC and drives the instruction-memory request handshake.
//  Holds PC and IF/ID while the hazard-detection stall is asserted.
//  Applies ID-stage branch/jump redirects, squashing the instruction in IF/ID.
// PARAMETERS
//  ADDR_W    32            PC / imem address width
//  INSTR_W   32            instruction width
//  RESET_PC  32'h0000_0000 first fetch address after reset (bits [1:0] must be 0)
// PORTS
//  clk_i            in   1        clock, all state updates on rising edge
//  rst_i            in   1        synchronous reset, active-high
//  stall_i          in   1        hazard stall: hold PC and IF/ID this cycle
//  redirect_i       in   1        taken branch/jump resolved in ID
//  redirect_pc_i    in   ADDR_W   redirect target; bits [1:0] ignored (forced 0)
//  imem_req_o       out  1        fetch request valid
//  imem_addr_o      out  ADDR_W   fetch address (= PC), bits [1:0] always 0
//  imem_ready_i     in   1        imem_rdata_i valid for current request this cycle
//  imem_rdata_i     in   INSTR_W  fetched instruction
//  ifid_valid_o     out  1        IF/ID holds a real instruction
//  ifid_pc_o        out  ADDR_W   PC of instruction in IF/ID
//  ifid_pc4_o       out  ADDR_W   ifid_pc_o + 4
//  ifid_instr_o     out  INSTR_W  instruction in IF/ID (0 = NOP when bubble)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, redirect-pending=0, hold buffer=0;
//   ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=0, ifid_instr_o=0. Reset beats all inputs.
//  FSM states: FETCH, HELD, DRAIN.
//  FETCH: imem_req_o=1, imem_addr_o=pc; address stable until imem_ready_i=1.
//   ready & redirect: discard rdata; pc<=target; IF/ID<=bubble; stay FETCH.
//   ready & !stall: IF/ID<={1,pc,pc+4,rdata}; pc<=pc+4; stay FETCH.
//   ready & stall: IF/ID holds; rdata->hold buffer; pc unchanged; ->HELD.
//   !ready & redirect: latch target; IF/ID<=bubble; ->DRAIN.
//   !ready & !stall: IF/ID<=bubble (valid=0, instr=0, pc fields=0).
//   !ready & stall: IF/ID holds.
//  HELD: imem_req_o=0 (addr still = pc).
//   redirect: drop buffer; pc<=target; IF/ID<=bubble; ->FETCH.
//   stall: hold everything.
//   !stall: IF/ID<={1,pc,pc+4,buffer}; pc<=pc+4; ->FETCH.
//  DRAIN: imem_req_o=1, addr = old pc, until imem_ready_i; rdata discarded.
//   !stall: IF/ID<=bubble; stall: IF/ID holds.
//   New redirect in DRAIN overwrites the latched target.
//   On ready: pc<=latched target; ->FETCH.
//  Priority per edge: rst_i > redirect_i > stall_i. redirect_i always squashes IF/ID.
//  Latency: zero-wait imem (ready=1 in the request cycle) gives 1 instr/cycle.
//   Instr fetched in cycle N appears in IF/ID in cycle N+1.
//  Arithmetic: pc+4 modulo 2^ADDR_W (0xFFFF_FFFC+4 -> 0x0); no overflow flag.
//  No combinational path from stall_i/redirect_i to imem_addr_o.
//  imem_req_o is decoded from state only.
// TESTING
//  T1 reset, ready=1, no stall -> addr 0,4,8 on cycles 1-3; IF/ID valid from cycle 2,
//     pc 0,4,8 in sequence; pc4 = pc+4.
//  T2 stall_i=1 two cycles while IF/ID holds pc 0x8 and addr=0xC, ready=1
//     -> IF/ID stays 0x8; cycle 2 req=0 (HELD); after stall drops, IF/ID=0xC, addr=0x10.
//  T3 ready=0 for 3 cycles at addr 0x10, stall=0
//     -> addr stable 0x10, ifid_valid_o=0 three cycles, then IF/ID pc=0x10.
//  T4 redirect_i to 0x103 while ready=0 at 0x20
//     -> addr stays 0x20 until ready, data dropped, IF/ID bubble; next addr 0x100.
//  T5 redirect_i and stall_i together in HELD
//     -> buffer dropped, ifid_valid_o=0, next addr = target.
//  T6 RESET_PC=0xFFFF_FFFC -> second fetch addr 0x0.
//     rst_i mid-DRAIN -> next cycle state FETCH at RESET_PC, all outputs at reset values.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, drives the imem handshake,
// holds on hazard stalls and squashes IF/ID on ID-stage redirects (zero-wait imem gives 1 instr/cycle).
module if_fetch_stage #(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               ifid_valid_o,
    output logic [ADDR_W-1:0]  ifid_pc_o,
    output logic [ADDR_W-1:0]  ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic               vld_q, vld_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic [ADDR_W-1:0]  ipc4_q, ipc4_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_plus4;

    assign target   = redirect_pc_i & ~ADDR_W'(3);
    assign pc_plus4 = pc_q + ADDR_W'(4);

    assign imem_req_o   = (state_q != ST_HELD);
    assign imem_addr_o  = pc_q;
    assign ifid_valid_o = vld_q;
    assign ifid_pc_o    = ipc_q;
    assign ifid_pc4_o   = ipc4_q;
    assign ifid_instr_o = instr_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        buf_d   = buf_q;
        vld_d   = vld_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        instr_d = instr_q;

        // Redirect always squashes; otherwise an unstalled cycle without new data bubbles.
        if (redirect_i || (!stall_i && state_q != ST_HELD && !(state_q == ST_FETCH && imem_ready_i))) begin
            vld_d   = 1'b0;
            ipc_d   = '0;
            ipc4_d  = '0;
            instr_d = '0;
        end

        case (state_q)
            ST_FETCH: begin
                if (imem_ready_i) begin
                    if (redirect_i) begin
                        pc_d = target;
                    end else if (!stall_i) begin
                        vld_d   = 1'b1;
                        ipc_d   = pc_q;
                        ipc4_d  = pc_plus4;
                        instr_d = imem_rdata_i;
                        pc_d    = pc_plus4;
                    end else begin
                        buf_d   = imem_rdata_i;
                        state_d = ST_HELD;
                    end
                end else if (redirect_i) begin
                    tgt_d   = target;
                    state_d = ST_DRAIN;
                end
            end
            ST_HELD: begin
                if (redirect_i) begin
                    buf_d   = '0;
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (!stall_i) begin
                    vld_d   = 1'b1;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_plus4;
                    instr_d = buf_q;
                    pc_d    = pc_plus4;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The outstanding request must complete at the old PC before retargeting.
                if (redirect_i) begin
                    tgt_d = target;
                end
                if (imem_ready_i) begin
                    pc_d    = redirect_i ? target : tgt_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            buf_q   <= '0;
            vld_q   <= 1'b0;
            ipc_q   <= '0;
            ipc4_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            buf_q   <= buf_d;
            vld_q   <= vld_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; the imem returns addr ^ 0xDEAD_0000 as instruction.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, ready;
    logic [31:0] redirect_pc;
    logic        req, vld;
    logic [31:0] addr, rdata, ipc, ipc4, instr;
    logic        req2, vld2;
    logic [31:0] addr2, ipc2, ipc42, instr2;
    int          nchecks = 0;
    int          nerrors = 0;

    always #5 clk = ~clk;

    assign rdata = addr ^ 32'hDEAD_0000;

    if_fetch_stage dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ready_i(ready), .imem_rdata_i(rdata), .ifid_valid_o(vld),
        .ifid_pc_o(ipc), .ifid_pc4_o(ipc4), .ifid_instr_o(instr)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ready_i(ready), .imem_rdata_i(rdata), .ifid_valid_o(vld2),
        .ifid_pc_o(ipc2), .ifid_pc4_o(ipc42), .ifid_instr_o(instr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
        chk({tag, "_vld"}, {31'd0, vld}, {31'd0, v});
        chk({tag, "_pc"}, ipc, p);
        chk({tag, "_pc4"}, ipc4, v ? p + 32'd4 : 32'd0);
        chk({tag, "_instr"}, instr, i);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; ready = 1'b1; redirect_pc = '0;
        step();
        chk("rst_req", {31'd0, req}, 32'd1);
        chk("rst_addr", addr, 32'h0);
        chk_ifid("rst", 1'b0, 32'h0, 32'h0);
        chk("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
        rst = 1'b0;

        // T1: back-to-back fetches
        step();
        chk("t1_addr4", addr, 32'h4);
        chk_ifid("t1_c2", 1'b1, 32'h0, 32'hDEAD_0000);
        chk("t6_wrap_addr", addr2, 32'h0);
        chk("t6_wrap_pc4", ipc42, 32'h0);
        chk("t6_wrap_pc", ipc2, 32'hFFFF_FFFC);
        step();
        chk("t1_addr8", addr, 32'h8);
        chk_ifid("t1_c3", 1'b1, 32'h4, 32'hDEAD_0004);
        step();
        chk("t1_addrC", addr, 32'hC);
        chk_ifid("t1_c4", 1'b1, 32'h8, 32'hDEAD_0008);

        // T2: two stall cycles while a ready fetch of 0xC lands in the hold buffer
        stall = 1'b1;
        step();
        chk("t2_req_held", {31'd0, req}, 32'd0);
        chk("t2_addr_held", addr, 32'hC);
        chk_ifid("t2_hold1", 1'b1, 32'h8, 32'hDEAD_0008);
        step();
        chk("t2_req_held2", {31'd0, req}, 32'd0);
        chk_ifid("t2_hold2", 1'b1, 32'h8, 32'hDEAD_0008);
        stall = 1'b0;
        step();
        chk("t2_req_back", {31'd0, req}, 32'd1);
        chk("t2_addr10", addr, 32'h10);
        chk_ifid("t2_release", 1'b1, 32'hC, 32'hDEAD_000C);

        // T3: three wait states at 0x10
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_addr_stable", addr, 32'h10);
            chk_ifid("t3_bubble", 1'b0, 32'h0, 32'h0);
        end
        ready = 1'b1;
        step();
        chk("t3_addr14", addr, 32'h14);
        chk_ifid("t3_done", 1'b1, 32'h10, 32'hDEAD_0010);
        step(); step(); step();
        chk("t4_addr20", addr, 32'h20);

        // T4: redirect while the imem is not ready
        ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0; redirect_pc = '0;
        chk("t4_drain_addr", addr, 32'h20);
        chk("t4_drain_req", {31'd0, req}, 32'd1);
        chk_ifid("t4_drain1", 1'b0, 32'h0, 32'h0);
        step();
        chk("t4_drain_addr2", addr, 32'h20);
        ready = 1'b1;
        step();
        chk("t4_target", addr, 32'h100);
        chk_ifid("t4_dropped", 1'b0, 32'h0, 32'h0);
        step();
        chk("t4_addr104", addr, 32'h104);
        chk_ifid("t4_first", 1'b1, 32'h100, 32'hDEAD_0100);

        // T5: redirect together with stall while HELD
        stall = 1'b1;
        step();
        chk("t5_req_held", {31'd0, req}, 32'd0);
        chk_ifid("t5_hold", 1'b1, 32'h100, 32'hDEAD_0100);
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        chk("t5_target", addr, 32'h200);
        chk("t5_req", {31'd0, req}, 32'd1);
        chk_ifid("t5_squash", 1'b0, 32'h0, 32'h0);
        step();
        chk_ifid("t5_first", 1'b1, 32'h200, 32'hDEAD_0200);

        // T6: reset while draining toward a redirect target
        ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0; rst = 1'b1;
        step();
        chk("t6_rst_addr", addr, 32'h0);
        chk("t6_rst_req", {31'd0, req}, 32'd1);
        chk_ifid("t6_rst", 1'b0, 32'h0, 32'h0);
        rst = 1'b0; ready = 1'b1;
        step();
        chk("t6_fetch_addr", addr, 32'h4);
        chk_ifid("t6_fetch", 1'b1, 32'h0, 32'hDEAD_0000);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
